// File: rtl/conv_pkg.sv
// Shared helpers for the streaming 2-D convolution engine: kernel range check, accumulator
// sizing and the default (generalised Laplacian) coefficient set.
package conv_pkg;

  localparam int KMin    = 3;
  localparam int KMax    = 7;
  localparam int MaxTaps = KMax * KMax;

  // Coefficient table sized for the largest supported kernel, row-major r*K+c.
  typedef int coef_table_t [MaxTaps];

  function automatic bit k_valid(int k);
    return (k >= KMin) && (k <= KMax) && ((k % 2) == 1);
  endfunction

  function automatic int acc_width(int word_w, int coef_w, int k);
    return word_w + coef_w + 1 + $clog2(k * k);
  endfunction

  function automatic int default_coef(int k, int idx);
    return (idx == (k * k) / 2) ? (k * k - 1) : -1;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Raster line buffer: stores the most recent accepted pixels and presents the KxK window around
// the pixel being accepted, flattened row-major (tap r*K+c at [(r*K+c)*WORD_SIZE +: WORD_SIZE]).
module conv_line_buffer #(
  parameter int WORD_SIZE  = 8,
  parameter int ROW_SIZE   = 540,
  parameter int KERNEL_DIM = 3
) (
  input  logic                                          clk,
  input  logic                                          i_en,
  input  logic                                          i_valid,
  input  logic [WORD_SIZE-1:0]                          i_pixel,
  output logic [KERNEL_DIM*KERNEL_DIM*WORD_SIZE-1:0]    o_window
);

  // The incoming pixel is the newest tap, so only the older span is stored.
  localparam int Depth = (KERNEL_DIM - 1) * ROW_SIZE + KERNEL_DIM - 1;

  logic [WORD_SIZE-1:0] r_buf [Depth];
  logic                 w_shift;

  assign w_shift = i_en && i_valid;

  always_ff @(posedge clk) begin
    if (w_shift) begin
      r_buf[0] <= i_pixel;
      for (int i = 1; i < Depth; i++) begin
        r_buf[i] <= r_buf[i-1];
      end
    end
  end

  for (genvar r = 0; r < KERNEL_DIM; r++) begin : g_row
    for (genvar c = 0; c < KERNEL_DIM; c++) begin : g_col
      localparam int Age = (KERNEL_DIM - 1 - r) * ROW_SIZE + (KERNEL_DIM - 1 - c);
      if (Age == 0) begin : g_new
        assign o_window[(r*KERNEL_DIM+c)*WORD_SIZE +: WORD_SIZE] = i_pixel;
      end else begin : g_old
        assign o_window[(r*KERNEL_DIM+c)*WORD_SIZE +: WORD_SIZE] = r_buf[Age-1];
      end
    end
  end

endmodule

// File: rtl/conv2d_stream.sv
// Streaming KxK convolution with valid/ready flow control, runtime coefficients and a saturated
// 3-stage pipeline. Define CONV_ABS_EN to output the saturated magnitude instead of clamping at 0.
module conv2d_stream
  import conv_pkg::*;
#(
  parameter int WORD_SIZE  = 8,
  parameter int ROW_SIZE   = 540,
  parameter int KERNEL_DIM = 3,
  parameter int COEF_WIDTH = 8,
  parameter int SHIFT      = 0
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [WORD_SIZE-1:0]                          in_pixel,
  input  logic                                          in_sof,
  input  logic                                          coef_we,
  input  logic [$clog2(KERNEL_DIM*KERNEL_DIM)-1:0]      coef_addr,
  input  logic [COEF_WIDTH-1:0]                         coef_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [WORD_SIZE-1:0]                          out_pixel
);

  localparam int Taps  = KERNEL_DIM * KERNEL_DIM;
  localparam int ColW  = $clog2(ROW_SIZE);
  localparam int RowW  = $clog2(KERNEL_DIM);
  localparam int ProdW = WORD_SIZE + COEF_WIDTH + 1;
  localparam int AccW  = acc_width(WORD_SIZE, COEF_WIDTH, KERNEL_DIM);

  localparam logic [ColW-1:0] ColLast  = ColW'(ROW_SIZE - 1);
  localparam logic [ColW-1:0] ColFirst = ColW'(KERNEL_DIM - 1);
  localparam logic [RowW-1:0] RowLast  = RowW'(KERNEL_DIM - 1);
  localparam logic signed [AccW-1:0] PixMax =
    {{(AccW - WORD_SIZE){1'b0}}, {WORD_SIZE{1'b1}}};

  if (!k_valid(KERNEL_DIM)) begin : g_k_check
    $error("KERNEL_DIM must be odd and within 3..7");
  end

  logic                             w_en, w_accept, w_win_valid;
  logic [ColW-1:0]                  r_col, w_col_cur;
  logic [RowW-1:0]                  r_row, w_row_cur;
  logic [Taps*WORD_SIZE-1:0]        w_window;
  logic signed [COEF_WIDTH-1:0]     r_coef [Taps];
  logic signed [ProdW-1:0]          w_prod [Taps];
  logic signed [ProdW-1:0]          r_prod [Taps];
  logic signed [AccW-1:0]           w_sum, r_acc, w_shifted, w_mag;
  logic [WORD_SIZE-1:0]             w_sat, r_out_pixel;
  logic                             r_s1_valid, r_s2_valid, r_out_valid;

  // A single enable stalls the whole engine while the output is held.
  assign w_en      = !r_out_valid || out_ready;
  assign w_accept  = in_valid && w_en;
  assign in_ready  = w_en;
  assign out_valid = r_out_valid;
  assign out_pixel = r_out_pixel;

  assign w_col_cur   = in_sof ? '0 : r_col;
  assign w_row_cur   = in_sof ? '0 : r_row;
  assign w_win_valid = (w_row_cur == RowLast) && (w_col_cur >= ColFirst);

  conv_line_buffer #(
    .WORD_SIZE (WORD_SIZE),
    .ROW_SIZE  (ROW_SIZE),
    .KERNEL_DIM(KERNEL_DIM)
  ) u_line_buffer (
    .clk     (clk),
    .i_en    (w_en),
    .i_valid (in_valid),
    .i_pixel (in_pixel),
    .o_window(w_window)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_cur == ColLast) begin
        r_col <= '0;
        r_row <= (w_row_cur == RowLast) ? RowLast : w_row_cur + RowW'(1);
      end else begin
        r_col <= w_col_cur + ColW'(1);
        r_row <= w_row_cur;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Taps; i++) begin
        r_coef[i] <= COEF_WIDTH'(default_coef(KERNEL_DIM, i));
      end
    end else if (coef_we && (int'(coef_addr) < Taps)) begin
      r_coef[coef_addr] <= coef_data;
    end
  end

  always_comb begin
    for (int i = 0; i < Taps; i++) begin
      w_prod[i] = ProdW'($signed({1'b0, w_window[i*WORD_SIZE +: WORD_SIZE]})) *
                  ProdW'(r_coef[i]);
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < Taps; i++) begin
      w_sum = w_sum + AccW'(r_prod[i]);
    end
  end

  always_comb begin
    w_shifted = r_acc >>> SHIFT;
`ifdef CONV_ABS_EN
    w_mag = w_shifted[AccW-1] ? -w_shifted : w_shifted;
`else
    w_mag = w_shifted[AccW-1] ? '0 : w_shifted;
`endif
    w_sat = (w_mag > PixMax) ? '1 : w_mag[WORD_SIZE-1:0];
  end

  // Datapath registers carry no reset; the stage valids gate them.
  always_ff @(posedge clk) begin
    if (w_en) begin
      r_prod <= w_prod;
      r_acc  <= w_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_pixel <= '0;
    end else if (w_en) begin
      r_s1_valid  <= w_accept && w_win_valid;
      r_s2_valid  <= r_s1_valid;
      r_out_valid <= r_s2_valid;
      r_out_pixel <= w_sat;
    end
  end

endmodule
